ctrl_clk_div: RTL
=================

CTRL_CLK_DIV -- requirements
Module: ctrl_clk_div

Interface
REQ-001 Parameter NUM_CH, default 5, number of derived clock channels (1..16).
REQ-002 Parameter DIV_W, default 8, width of each channel divide ratio.
REQ-003 Parameter DIV_INIT, default 1, divide ratio loaded into every channel at reset.
REQ-004 Parameter LOCK_CYCLES, default 16, settle count before locked asserts (>=1).
REQ-005 inclk0  input  1  sole clock; all logic on rising edge.
REQ-006 areset  input  1  asynchronous, active-high reset.
REQ-007 cfg_valid  input  1  divide-ratio update request.
REQ-008 cfg_ch  input  max(1,$clog2(NUM_CH))  target channel index.
REQ-009 cfg_div  input  DIV_W  new divide ratio N; 0 = channel stopped.
REQ-010 cfg_ready  output  1  update can be accepted this cycle.
REQ-011 ce  output  NUM_CH  per-channel one-cycle clock-enable pulse.
REQ-012 c  output  NUM_CH  per-channel registered divided clock level.
REQ-013 locked  output  1  all channels settled on current ratios.

Function
REQ-014 Each channel SHALL hold a DIV_W-bit counter cnt counting 0..N-1 and wrapping to 0, where N is its active ratio.
REQ-015 ce[i] SHALL be 1 for exactly the cycle where cnt==N-1; N=1 gives ce[i] constantly 1.
REQ-016 c[i] SHALL be registered, 1 while cnt < ceil(N/2), else 0; N=1 gives c[i] constantly 1.
REQ-017 N=0 SHALL hold cnt at 0, ce[i]=0, c[i]=0.
REQ-018 An update SHALL be accepted on a cycle where cfg_valid && cfg_ready.
REQ-019 Accepted update with cfg_ch >= NUM_CH SHALL be discarded with no other effect.
REQ-020 Accepted update to a running channel SHALL be stored as pending and applied on that channel's cycle with ce[i]=1, cnt restarting at 0 next cycle (glitch-free; no shortened period).
REQ-021 Accepted update to a stopped channel (active N=0) SHALL apply in the next cycle, cnt=0.
REQ-022 cfg_ready SHALL be 0 while any channel has a pending update, else 1; at most one update outstanding.
REQ-023 Lock FSM states: WAIT, LOCKED. WAIT loads settle counter with LOCK_CYCLES-1 and decrements each cycle while no update pending; at 0 -> LOCKED.
REQ-024 locked SHALL be 1 only in LOCKED.
REQ-025 In LOCKED, an accepted valid-channel update SHALL force WAIT with locked=0 on the next cycle and counter reloaded.
REQ-026 In WAIT, a new accepted valid-channel update SHALL reload the counter (restart settle).
REQ-027 Settle counter SHALL not decrement while a pending update exists.
REQ-028 cfg_div equal to current active N SHALL still be treated as an update (pending, relock).
REQ-029 Counters SHALL compare in DIV_W bits; N=2^DIV_W-1 SHALL work without overflow.

Reset
REQ-030 areset high SHALL immediately force: all cnt=0, active N=DIV_INIT, pending cleared, ce=0, c=0, cfg_ready=0, lock FSM=WAIT, locked=0.
REQ-031 First rising edge after areset release SHALL set cfg_ready=1 and start the settle count; channel outputs follow REQ-015/016 from that edge.
REQ-032 areset asserted mid-update SHALL discard the pending ratio; DIV_INIT restored.
REQ-033 locked SHALL first assert LOCK_CYCLES cycles after the first edge following release.

Verification
REQ-034 Defaults, release reset, no cfg -> ce all 1 every cycle, c all 1, locked rises exactly 16 cycles after first post-release edge.
REQ-035 Write ch2 N=4 while locked -> locked drops next cycle; ch2 period changes only after current ce; then ce[2] every 4 cycles, c[2] pattern 1,1,0,0; locked returns 16 cycles after apply.
REQ-036 Write ch1 N=5 then ch1 N=0 -> c[1] 1,1,1,0,0 repeating, ce[1] on cnt 4; after second write ce[1]=0, c[1]=0 held; cfg_ready low during each pending interval.
REQ-037 cfg_ch=7 with NUM_CH=5 -> accepted, no channel change, locked unchanged.
REQ-038 DIV_W=8, write N=255 to ch0 -> ce[0] every 255 cycles, c[0] high 128 cycles, low 127.
REQ-039 Assert areset with ch3 update pending -> all outputs 0 asynchronously; after release ch3 runs at DIV_INIT, no late application of old ratio.

Source files
------------

// File: rtl/ctrl_clk_div.sv
// Multi-channel programmable clock-enable / divided-clock generator with a
// glitch-free ratio update path and a settle-based lock indicator.
module ctrl_clk_div #(
  parameter int NUM_CH      = 5,
  parameter int DIV_W       = 8,
  parameter int DIV_INIT    = 1,
  parameter int LOCK_CYCLES = 16,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              inclk0,
  input  logic              areset,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] c,
  output logic              locked
);

  localparam int SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic {WAIT, LOCKED} lock_state_t;

  lock_state_t state, state_nx;

  logic              run;
  logic [DIV_W-1:0]  act    [NUM_CH];
  logic [DIV_W-1:0]  act_nx [NUM_CH];
  logic [DIV_W-1:0]  cnt    [NUM_CH];
  logic [DIV_W-1:0]  cnt_nx [NUM_CH];
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] ce_nx;
  logic [NUM_CH-1:0] c_nx;
  logic [NUM_CH-1:0] ce_q;
  logic [NUM_CH-1:0] c_q;

  logic              pend_valid;
  logic [CH_W-1:0]   pend_ch;
  logic [DIV_W-1:0]  pend_div;
  logic              pend_done;
  logic              tgt_stopped;

  logic              accept;
  logic              ch_ok;
  logic              upd;
  logic [SET_W-1:0]  settle;

  function automatic logic [DIV_W-1:0] half_up(input logic [DIV_W-1:0] n);
    return (n >> 1) + DIV_W'(n[0]);
  endfunction

  assign cfg_ready = run && !pend_valid;
  assign accept    = cfg_valid && cfg_ready;
  assign ch_ok     = int'(cfg_ch) < NUM_CH;
  assign upd       = accept && ch_ok;
  assign ce        = ce_q;
  assign c         = c_q;

  // run stays low until the first edge after reset release so every output
  // (including cfg_ready) starts from that edge.
  always_ff @(posedge inclk0 or posedge areset) begin
    if (areset) run <= 1'b0;
    else        run <= 1'b1;
  end

  // A running channel only swaps ratio on its wrap cycle; a stopped channel
  // takes the new ratio straight away. Outputs are decoded from next state so
  // ce/c line up with the registered counter.
  always_comb begin
    pend_done   = 1'b0;
    tgt_stopped = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      act_nx[i] = act[i];
      cnt_nx[i] = cnt[i];
      wrap[i]   = (act[i] != '0) && (cnt[i] == act[i] - DIV_W'(1));
      hit[i]    = (cfg_ch == CH_W'(i));
      if (hit[i] && act[i] == '0)
        tgt_stopped = 1'b1;
      if (run) begin
        if (act[i] == '0) begin
          cnt_nx[i] = '0;
          if (upd && hit[i])
            act_nx[i] = cfg_div;
        end else if (wrap[i]) begin
          cnt_nx[i] = '0;
          if (pend_valid && pend_ch == CH_W'(i)) begin
            act_nx[i] = pend_div;
            pend_done = 1'b1;
          end
        end else begin
          cnt_nx[i] = cnt[i] + DIV_W'(1);
        end
      end
      ce_nx[i] = (act_nx[i] != '0) && (cnt_nx[i] == act_nx[i] - DIV_W'(1));
      c_nx[i]  = (act_nx[i] != '0) && (cnt_nx[i] < half_up(act_nx[i]));
    end
  end

  always_ff @(posedge inclk0 or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        act[i] <= DIV_W'(DIV_INIT);
        cnt[i] <= '0;
      end
      ce_q <= '0;
      c_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        act[i] <= act_nx[i];
        cnt[i] <= cnt_nx[i];
      end
      ce_q <= ce_nx;
      c_q  <= c_nx;
    end
  end

  // Single outstanding update slot; only used for channels that are running.
  always_ff @(posedge inclk0 or posedge areset) begin
    if (areset) begin
      pend_valid <= 1'b0;
      pend_ch    <= '0;
      pend_div   <= '0;
    end else if (pend_done) begin
      pend_valid <= 1'b0;
    end else if (upd && !tgt_stopped) begin
      pend_valid <= 1'b1;
      pend_ch    <= cfg_ch;
      pend_div   <= cfg_div;
    end
  end

  always_ff @(posedge inclk0 or posedge areset) begin
    if (areset) state <= WAIT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      WAIT:    if (!upd && run && !pend_valid && settle == '0) state_nx = LOCKED;
      LOCKED:  if (upd) state_nx = WAIT;
      default: state_nx = WAIT;
    endcase
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  // Settle count freezes while a ratio is waiting for its wrap point.
  always_ff @(posedge inclk0 or posedge areset) begin
    if (areset)
      settle <= SET_W'(LOCK_CYCLES - 1);
    else if (upd)
      settle <= SET_W'(LOCK_CYCLES - 1);
    else if (state == WAIT && run && !pend_valid && settle != '0)
      settle <= settle - SET_W'(1);
  end

endmodule
